cpc_slot_ctrl: RTL and testbench

Active slot controller for the next-generation CPC expansion backplane. Replaces hard-wired power links with per-slot power switches, buffer enables and slot resets for a parametrised number of slots. After reset it powers the slots one at a time to limit inrush, then releases slot reset and bus buffers. The Z80 can rewrite the slot-enable mask and read status through one I/O port pair decoded from the CPC expansion bus.

---
 rtl/cpc_slot_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpc_slot_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_slot_ctrl.sv
// cpc_slot_ctrl: staggered power-up/down of CPC expansion slots behind a Z80 mask/fault port pair.
// Define SLOT_FAULT_EN to latch per-slot overcurrent flags from FAULT_B; otherwise FAULT reads as 0.
module cpc_slot_ctrl #(
  parameter int                   NUM_SLOTS      = 4,
  parameter int                   STAGGER_CYCLES = 4000,
  parameter logic [7:0]           IO_ADDR_HI     = 8'hF9,
  parameter logic [NUM_SLOTS-1:0] RESET_MASK     = {NUM_SLOTS{1'b1}}
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic [7:0]           A_HI,
  input  logic                 A0,
  input  logic [7:0]           D_IN,
  output logic [7:0]           D_OUT,
  output logic                 D_OE,
  input  logic                 IOREQ_B,
  input  logic                 RD_B,
  input  logic                 WR_B,
  input  logic                 M1_B,
  input  logic [NUM_SLOTS-1:0] FAULT_B,
  output logic [NUM_SLOTS-1:0] SLOT_PWR_EN,
  output logic [NUM_SLOTS-1:0] SLOT_BUS_EN,
  output logic [NUM_SLOTS-1:0] SLOT_RESET_B,
  output logic                 BUSY
);

  localparam int               CNT_W    = $clog2(STAGGER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_FULL) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] lowest_one(input logic [NUM_SLOTS-1:0] v);
    return v & (~v + NUM_SLOTS'(1));
  endfunction

  function automatic logic [7:0] zext(input logic [NUM_SLOTS-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_SLOTS-1:0] = v;
    return r;
  endfunction

  typedef enum logic [2:0] {IDLE, WAIT, POWER, SETTLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_SLOTS-1:0] mask, fault, down;
  logic [NUM_SLOTS-1:0] tgt, pend, pick, down_start, keep;
  logic [NUM_SLOTS-1:0] pwr_nx, bus_nx;
  logic                 sel, wr_now, wr_prev, wr_ev, rd_now;
  logic                 unused_inputs;

  // Bus decode: interrupt acknowledge cycles never count as port accesses
  assign sel    = ~IOREQ_B & M1_B & (A_HI == IO_ADDR_HI);
  assign wr_now = sel & ~WR_B;
  assign wr_ev  = wr_now & ~wr_prev;
  assign rd_now = sel & ~RD_B;
  assign D_OE   = rd_now;
  assign D_OUT  = rd_now ? (A0 ? zext(fault) : zext(mask)) : 8'h00;
  assign unused_inputs = ^{D_IN, FAULT_B};

`ifdef SLOT_FAULT_EN
  logic [NUM_SLOTS-1:0] fault_clr;
  assign fault_clr = (wr_ev & A0) ? D_IN[NUM_SLOTS-1:0] : '0;

  always_ff @(posedge CLK) begin
    if (!RESET_B) fault <= '0;
    else          fault <= (fault & ~fault_clr) | (~FAULT_B & SLOT_PWR_EN);
  end
`else
  assign fault = '0;
`endif

  // Per-slot targets: down marks slots isolated last cycle that lose power this cycle
  assign tgt        = mask & ~fault;
  assign pend       = tgt & ~SLOT_PWR_EN;
  assign pick       = lowest_one(pend);
  assign down_start = SLOT_PWR_EN & ~tgt & ~down;
  assign keep       = SLOT_PWR_EN & tgt & ~down;

  always_comb begin
    pwr_nx = SLOT_PWR_EN & ~down;
    bus_nx = SLOT_BUS_EN & ~down_start;
    if (state == POWER) pwr_nx = pwr_nx | pick;
    if (state == SETTLE && cnt == CNT_FULL) bus_nx = bus_nx | keep;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state        <= WAIT;
      cnt          <= '0;
      mask         <= RESET_MASK;
      down         <= '0;
      wr_prev      <= 1'b0;
      SLOT_PWR_EN  <= '0;
      SLOT_BUS_EN  <= '0;
      SLOT_RESET_B <= '0;
      BUSY         <= 1'b1;
    end else begin
      wr_prev      <= wr_now;
      down         <= down_start;
      SLOT_PWR_EN  <= pwr_nx;
      SLOT_BUS_EN  <= bus_nx;
      SLOT_RESET_B <= bus_nx;
      if (wr_ev && !A0) mask <= D_IN[NUM_SLOTS-1:0];
      case (state)
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= POWER;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        // Look ahead so the settle delay starts right after the last slot powers
        POWER: begin
          cnt   <= '0;
          state <= ((pend & ~pick) != '0) ? WAIT : SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_FULL) begin
            state <= (keep != '0) ? RUN : IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          // The cycle spent noticing new work counts as the first wait cycle
          if (pend != '0) begin
            BUSY <= 1'b1;
            if (STAGGER_CYCLES == 1) begin
              state <= POWER;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_ONE;
            end
          end else begin
            state <= (SLOT_PWR_EN != '0) ? RUN : IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_slot_ctrl.sv
// Scoreboard bench for cpc_slot_ctrl: a deadline-based reference model predicts slot outputs per edge,
// a negedge monitor pops and compares them, and read data is matched whenever D_OE is presented.
`timescale 1ns/1ps
module tb_cpc_slot_ctrl;
  localparam int         NS        = 4;
  localparam int         SC        = 8;
  localparam logic [7:0] ADDR      = 8'hF9;
  localparam int         PH_RUN    = 0;
  localparam int         PH_SEQ    = 1;
  localparam int         PH_SETTLE = 2;

  logic          clk = 1'b0;
  logic          reset_b, a0, ioreq_b, rd_b, wr_b, m1_b, d_oe, busy;
  logic [7:0]    a_hi, d_in, d_out;
  logic [NS-1:0] fault_b, pwr, bus, srst;

  cpc_slot_ctrl #(.NUM_SLOTS(NS), .STAGGER_CYCLES(SC), .IO_ADDR_HI(ADDR), .RESET_MASK(4'hF)) dut (
    .CLK(clk), .RESET_B(reset_b), .A_HI(a_hi), .A0(a0), .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe),
    .IOREQ_B(ioreq_b), .RD_B(rd_b), .WR_B(wr_b), .M1_B(m1_b), .FAULT_B(fault_b),
    .SLOT_PWR_EN(pwr), .SLOT_BUS_EN(bus), .SLOT_RESET_B(srst), .BUSY(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] pwr;
    logic [NS-1:0] bus;
    logic          busy;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] rdq[$];
  int         total = 0;
  int         bad   = 0;
  int         t     = 0;
  int         t_ev  = 0;

  logic [NS-1:0] m_mask, m_fault, m_pwr, m_bus, m_down;
  logic          m_busy;
  int            m_phase, m_deadline;
  logic          ev_valid, ev_a0;
  logic [7:0]    ev_data;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, t);
    end
  endfunction

  // Model: next power step / release happens at an absolute cycle deadline
  task automatic model_edge();
    logic [NS-1:0] tgt, pend, n_pwr, n_bus, n_down, rem;
    int pick;
    if (!reset_b) begin
      m_mask = '1; m_fault = '0; m_pwr = '0; m_bus = '0; m_down = '0; m_busy = 1'b1;
      m_phase = PH_SEQ; m_deadline = t + SC + 1;
      return;
    end
    tgt    = m_mask & ~m_fault;
    pend   = tgt & ~m_pwr;
    n_pwr  = m_pwr & ~m_down;
    n_down = m_pwr & ~tgt & ~m_down;
    n_bus  = m_bus & ~n_down;
    case (m_phase)
      PH_RUN: if (pend != '0) begin
        m_phase = PH_SEQ; m_deadline = t + SC; m_busy = 1'b1;
      end
      PH_SEQ: if (t == m_deadline) begin
        pick = -1;
        for (int k = NS - 1; k >= 0; k--) if (pend[k]) pick = k;
        rem = pend;
        if (pick >= 0) begin n_pwr[pick] = 1'b1; rem[pick] = 1'b0; end
        m_phase = (rem != '0) ? PH_SEQ : PH_SETTLE;
        m_deadline = t + SC + 1;
      end
      PH_SETTLE: if (t == m_deadline) begin
        n_bus = n_bus | (m_pwr & tgt & ~m_down);
        m_phase = PH_RUN; m_busy = 1'b0;
      end
      default: ;
    endcase
    if (ev_valid && !ev_a0) m_mask = ev_data[NS-1:0];
`ifdef SLOT_FAULT_EN
    m_fault = (m_fault & ~((ev_valid && ev_a0) ? ev_data[NS-1:0] : 4'h0)) | (~fault_b & m_pwr);
`endif
    m_pwr = n_pwr; m_bus = n_bus; m_down = n_down;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    t++;
    model_edge();
    e.pwr = m_pwr; e.bus = m_bus; e.busy = m_busy;
    sbq.push_back(e);
    ev_valid = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic wa0, input logic [7:0] data, input int len,
                          input logic wm1, input logic addr_ok);
    a_hi = addr_ok ? ADDR : (ADDR ^ 8'h10);
    a0 = wa0; d_in = data; m1_b = wm1; ioreq_b = 1'b0; wr_b = 1'b0;
    ev_valid = wm1 && addr_ok; ev_a0 = wa0; ev_data = data;
    t_ev = t + 1;
    for (int i = 0; i < len; i++) begin
      step();
      d_in = ~data;
    end
    ioreq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    step();
  endtask

  task automatic do_read(input logic ra0, input logic rm1, input logic addr_ok);
    a_hi = addr_ok ? ADDR : (ADDR ^ 8'h01);
    a0 = ra0; m1_b = rm1; ioreq_b = 1'b0; rd_b = 1'b0;
    if (rm1 && addr_ok) rdq.push_back(ra0 ? 8'(m_fault) : 8'(m_mask));
    step();
    ioreq_b = 1'b1; rd_b = 1'b1; m1_b = 1'b1;
  endtask

  task automatic fault_pulse(input int k);
    fault_b[k] = 1'b0;
    step();
    fault_b = '1;
  endtask

  initial begin
    exp_t e;
    logic exp_oe;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pwr_en", pwr, e.pwr);
        chk("bus_en", bus, e.bus);
        chk("slot_reset_b", srst, e.bus);
        chk("busy", busy, e.busy);
      end
      exp_oe = (rdq.size() > 0);
      chk("d_oe", d_oe, exp_oe);
      if (exp_oe) chk("d_out", d_out, rdq.pop_front());
      else        chk("d_out_idle", d_out, 0);
    end
  end

  initial begin
    int r;
    reset_b = 1'b0; a_hi = 8'h00; a0 = 1'b0; d_in = 8'h00; ioreq_b = 1'b1; rd_b = 1'b1;
    wr_b = 1'b1; m1_b = 1'b1; fault_b = '1; ev_valid = 1'b0; ev_a0 = 1'b0; ev_data = 8'h00;
    repeat (3) step();
    chk("rst_pwr", pwr, 0); chk("rst_bus", bus, 0); chk("rst_srst", srst, 0);
    chk("rst_busy", busy, 1); chk("rst_d_oe", d_oe, 0);

    // Power-up timeline from reset release
    reset_b = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step();
      case (i)
        8:  chk("pwr_c8", pwr, 4'h0);
        9:  chk("pwr_c9", pwr, 4'h1);
        18: chk("pwr_c18", pwr, 4'h3);
        27: chk("pwr_c27", pwr, 4'h7);
        36: chk("pwr_c36", pwr, 4'hF);
        44: begin chk("bus_c44", bus, 4'h0); chk("busy_c44", busy, 1); end
        45: begin chk("bus_c45", bus, 4'hF); chk("srst_c45", srst, 4'hF); chk("busy_c45", busy, 0); end
        default: ;
      endcase
    end
    repeat (3) step();

    // Mask 05: slots 1 and 3 isolated, then unpowered
    do_write(1'b0, 8'h05, 1, 1'b1, 1'b1);
    chk("m05_bus", bus, 4'h5); chk("m05_pwr_hold", pwr, 4'hF);
    step();
    chk("m05_pwr", pwr, 4'h5); chk("m05_bus2", bus, 4'h5);
    do_read(1'b0, 1'b1, 1'b1);

    // Mask 07: slot 1 re-sequenced while 0 and 2 keep running
    do_write(1'b0, 8'h07, 1, 1'b1, 1'b1);
    while (t < t_ev + 20) begin
      step();
      chk("m07_keep", bus & 4'h5, 4'h5);
      if (t == t_ev + 8)  chk("m07_pwr_pre", pwr, 4'h5);
      if (t == t_ev + 9)  begin chk("m07_pwr", pwr, 4'h7); chk("m07_bus_pre", bus, 4'h5); end
      if (t == t_ev + 17) chk("m07_bus_pre2", bus, 4'h5);
      if (t == t_ev + 18) chk("m07_bus", bus, 4'h7);
    end

    // Long strobe yields one update; M1_B=0 is ignored for writes and reads
    do_write(1'b0, 8'h03, 5, 1'b1, 1'b1);
    do_read(1'b0, 1'b1, 1'b1);
    do_write(1'b0, 8'h0C, 3, 1'b0, 1'b1);
    do_read(1'b0, 1'b0, 1'b1);
    do_read(1'b0, 1'b1, 1'b1);
    do_write(1'b0, 8'h0F, 1, 1'b1, 1'b1);
    repeat (40) step();

    // Overcurrent on slot 2
    fault_pulse(2);
    step();
`ifdef SLOT_FAULT_EN
    chk("flt_bus", bus, 4'hB); chk("flt_pwr_hold", pwr, 4'hF);
`else
    chk("flt_bus", bus, 4'hF); chk("flt_pwr_hold", pwr, 4'hF);
`endif
    step();
`ifdef SLOT_FAULT_EN
    chk("flt_pwr", pwr, 4'hB);
`else
    chk("flt_pwr", pwr, 4'hF);
`endif
    do_read(1'b1, 1'b1, 1'b1);
    do_write(1'b1, 8'h04, 1, 1'b1, 1'b1);
    repeat (25) step();
    do_read(1'b1, 1'b1, 1'b1);

    // Reset during the second wait interval
    reset_b = 1'b0; step(); reset_b = 1'b1;
    repeat (14) step();
    chk("w2_pwr", pwr, 4'h1);
    reset_b = 1'b0; step();
    chk("w2_rst_pwr", pwr, 0); chk("w2_rst_bus", bus, 0); chk("w2_rst_busy", busy, 1);
    reset_b = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 8) chk("w2_re_pwr8", pwr, 4'h0);
      if (i == 9) chk("w2_re_pwr9", pwr, 4'h1);
    end

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50) step();
      else if (r < 64)
        do_write(1'($urandom_range(0, 3) == 0), 8'($urandom), $urandom_range(1, 4),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
      else if (r < 78)
        do_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
      else if (r < 97) fault_pulse($urandom_range(0, NS - 1));
      else begin
        reset_b = 1'b0;
        repeat ($urandom_range(1, 2)) step();
        reset_b = 1'b1;
      end
    end
    repeat (5) step();

    @(negedge clk);
    #1;
    chk("rdq_drained", rdq.size(), 0);
    chk("sbq_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
